// File: rtl/led_activity_driver.sv
// led_activity_driver
// Per-port Ethernet link/activity LED driver. Each port owns a TX LED and an
// RX LED. A lit LED means "link up"; a frame event turns it off for one blink
// half-period, aligned to an internally generated blink timebase. The block
// also provides an optional slow blink while the link is down, an output
// polarity option and a lamp-test override.
//
// LED index mapping: led_o[2p] is the TX LED of port p and led_o[2p+1] is the
// RX LED of port p. Internal per-LED vectors use the same layout.

module led_activity_driver #(
    parameter int NUM_PORTS     = 4,        // 1..16
    parameter int BLINK_DIV     = 6250000,  // cycles per blink half-period tick, >= 2
    parameter int SLOW_RATIO    = 4,        // ticks per slow link-down half-period, >= 1
    parameter int LINKDOWN_MODE = 0,        // 0: LEDs off on link down, 1: slow blink
    parameter int ACTIVE_LOW    = 0         // 1: lit LED drives 0 at the pin
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_PORTS-1:0]   has_link_i,
    input  logic [NUM_PORTS-1:0]   on_frame_sent_i,
    input  logic [NUM_PORTS-1:0]   on_frame_received_i,
    input  logic                   lamp_test_i,
    output logic [2*NUM_PORTS-1:0] led_o,
    output logic                   blink_phase_o
);

    localparam int NUM_LEDS = 2 * NUM_PORTS;
    localparam int DIV_W    = $clog2(BLINK_DIV);
    localparam int SLOW_W   = (SLOW_RATIO > 1) ? $clog2(SLOW_RATIO) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(BLINK_DIV - 1);
    localparam logic [SLOW_W-1:0]   SLOW_LAST = SLOW_W'(SLOW_RATIO - 1);
    localparam logic                INVERT    = (ACTIVE_LOW != 0);
    localparam logic                SLOW_MODE = (LINKDOWN_MODE != 0);
    // Pin value of an unlit LED, also the reset value of led_o.
    localparam logic [NUM_LEDS-1:0] UNLIT     = {NUM_LEDS{INVERT}};

    // Blink timebase state.
    logic [DIV_W-1:0]    div_q, div_d;
    logic                phase_q, phase_d;
    logic [SLOW_W-1:0]   slow_cnt_q, slow_cnt_d;
    logic                slow_phase_q, slow_phase_d;

    // Per-LED activity state.
    logic [NUM_LEDS-1:0] pending_q, pending_d;
    logic [NUM_LEDS-1:0] blinkoff_q, blinkoff_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    // Combinational helpers.
    logic                tick;
    logic                rise;
    logic                fall;
    logic                slow_wrap;
    logic [NUM_LEDS-1:0] event_vec;
    logic [NUM_LEDS-1:0] link_vec;
    logic [NUM_LEDS-1:0] lit;

    // Spread the per-port inputs onto the per-LED layout (TX even, RX odd).
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        event_vec = '0;
        link_vec  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            event_vec[2*p]   = on_frame_sent_i[p];
            event_vec[2*p+1] = on_frame_received_i[p];
            link_vec[2*p]    = has_link_i[p];
            link_vec[2*p+1]  = has_link_i[p];
        end
    end

    // Prescaler, fast blink phase and slow link-down phase next-state.
    always_comb begin
        tick      = (div_q == DIV_LAST);
        rise      = tick & ~phase_q;
        fall      = tick & phase_q;
        slow_wrap = tick & (slow_cnt_q == SLOW_LAST);

        div_d   = tick ? '0 : div_q + DIV_W'(1);
        phase_d = phase_q ^ tick;

        slow_cnt_d = slow_cnt_q;
        if (slow_wrap) begin
            slow_cnt_d = '0;
        end else if (tick) begin
            slow_cnt_d = slow_cnt_q + SLOW_W'(1);
        end
        slow_phase_d = slow_phase_q ^ slow_wrap;
    end

    // Activity capture: an event in the rise cycle is credited to the next window.
    always_comb begin
        pending_d  = pending_q | event_vec;
        blinkoff_d = blinkoff_q;
        if (rise) begin
            blinkoff_d = pending_q;
            pending_d  = event_vec;
        end else if (fall) begin
            blinkoff_d = '0;
        end
    end

    // LED lit value with lamp test and link-down policy, then pin polarity.
    always_comb begin
        if (lamp_test_i) begin
            lit = '1;
        end else begin
            lit = (link_vec & ~blinkoff_q)
                | (~link_vec & {NUM_LEDS{SLOW_MODE & slow_phase_q}});
        end
        led_d = lit ^ UNLIT;
    end

    // State registers; asynchronous reset puts every LED in its unlit state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q        <= '0;
            phase_q      <= 1'b0;
            slow_cnt_q   <= '0;
            slow_phase_q <= 1'b0;
            pending_q    <= '0;
            blinkoff_q   <= '0;
            led_q        <= UNLIT;
        end else begin
            // NOTE: state registers use non-blocking assignments so all of
            // them update from the same pre-edge values.
            div_q        <= div_d;
            phase_q      <= phase_d;
            slow_cnt_q   <= slow_cnt_d;
            slow_phase_q <= slow_phase_d;
            pending_q    <= pending_d;
            blinkoff_q   <= blinkoff_d;
            led_q        <= led_d;
        end
    end

    assign led_o         = led_q;
    assign blink_phase_o = phase_q;

endmodule

// File: doc/led_activity_driver.md
Name: led_activity_driver

Overview:
- Multi-port successor to the single-port Ethernet link/activity LED driver.
- Drives one TX LED and one RX LED per port. Each LED shows link state, and a blink-off pulse for frame activity.
- Generates its own blink timebase internally; no external blink input.
- Adds three things the single-port driver lacks: a slow link-down blink mode, an output polarity option and a lamp-test override.
- Sits between the MAC status/event outputs and the board LED pins.

Parameters:
- NUM_PORTS, 4, number of ports; 1..16.
- BLINK_DIV, 6250000, clock cycles per blink half-period tick; >= 2.
- SLOW_RATIO, 4, number of ticks per half-period of the slow link-down blink; >= 1.
- LINKDOWN_MODE, 0, link-down behaviour: 0 = LEDs off, 1 = both LEDs of the port blink slowly.
- ACTIVE_LOW, 0, output polarity: 1 = led_o inverted at the pin (lit = 0).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- has_link_i  in  NUM_PORTS  per-port link up; synchronous to clk_i.
- on_frame_sent_i  in  NUM_PORTS  one-cycle (or longer) TX event per port.
- on_frame_received_i  in  NUM_PORTS  RX event per port.
- lamp_test_i  in  1  forces all LEDs lit while high.
- led_o  out  2*NUM_PORTS  LED outputs, registered. led_o[2p] = TX LED of port p, led_o[2p+1] = RX LED of port p.
- blink_phase_o  out  1  current fast blink phase; for debug and chaining.

Behaviour:
- Reset (rst_n_i low, asynchronous): prescaler = 0; phase = 0; slow counter = 0; slow_phase = 0; all pending and blinkoff flags = 0; blink_phase_o = 0.
- Reset value of led_o: all LEDs unlit, i.e. all 0 when ACTIVE_LOW = 0 and all 1 when ACTIVE_LOW = 1.
- Reset mid-operation clears everything immediately, with no glitch beyond the asynchronous assertion itself.
- Prescaler:
  - Counts 0..BLINK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where the count = BLINK_DIV-1.
  - phase toggles on tick.
  - rise = tick & phase==0; fall = tick & phase==1.
- Slow counter:
  - Counts ticks 0..SLOW_RATIO-1.
  - slow_phase toggles on the tick where the count = SLOW_RATIO-1, then the counter wraps.
- Per port p, per direction d (TX, RX):
  - pending[p][d] is set by its event input in any cycle.
  - On rise: blinkoff[p][d] <= pending[p][d]. pending is then cleared, unless an event is present in that same cycle; in that case pending stays 1, so the event is credited to the next window.
  - On fall: blinkoff[p][d] <= 0.
  - Events on different ports and directions are independent. Simultaneous TX and RX events each set their own flag.
- Per-LED lit value (before polarity):
  - lamp_test_i = 1: lit.
  - Otherwise, has_link_i[p] = 1: lit = !blinkoff[p][d].
  - Otherwise, link down with LINKDOWN_MODE = 0: unlit.
  - Otherwise, link down with LINKDOWN_MODE = 1: lit = slow_phase.
- led_o = lit ^ ACTIVE_LOW, registered. Latency from internal state or input change to led_o is 1 cycle.
- Link drop while blinkoff = 1: the LED goes unlit (or follows the slow blink) next cycle. blinkoff itself still clears on the next fall.
- Event arriving while link is down: it is still captured. If link returns before the next rise, the blink is shown.
- No event in a window: the LED stays continuously lit; there is no extra blink.
- Activity duty cycle: the LED is off exactly BLINK_DIV cycles per active window.

Test Plan:
(All scenarios use BLINK_DIV = 4, SLOW_RATIO = 2, NUM_PORTS = 2, unless stated.)
- Reset release with has_link_i = 2'b11 and no events: led_o = 4'b0000 during reset, 4'b1111 one cycle after release, and stays 4'b1111 for 100 cycles. blink_phase_o toggles every 4 cycles.
- Single-cycle on_frame_sent_i[0] pulse mid low-phase: at the next rise, blinkoff is set and led_o[0] = 0 one cycle later for exactly 4 cycles, then returns to 1. led_o[3:1] stay 1.
- Event asserted exactly in the rise cycle: the current window shows no blink. The blink appears at the following rise, 8 cycles later.
- LINKDOWN_MODE = 1, has_link_i[1] = 0: led_o[3:2] toggle together every 8 cycles (SLOW_RATIO × 4). Port 0 is unaffected.
- ACTIVE_LOW = 1 and lamp_test_i = 1 with all links down: led_o = 4'b0000 one cycle after assertion. It returns to 4'b1111 (all unlit) one cycle after deassertion.
- Assert rst_n_i low while led_o[0] is blinked off: led_o goes to the unlit value immediately, without waiting for a clock edge. After release, the pending activity is gone and no blink occurs.
